// File: rtl/trap_controller_pkg.sv
// Shared types and constants for the pipeline-side trap controller:
// FSM states, the one-hot cause selector and the fixed priority order.
package trap_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RAISE    = 2'd1,
        S_WAIT     = 2'd2,
        S_REDIRECT = 2'd3
    } state_t;

    typedef struct packed {
        logic ill;
        logic ecall;
        logic ebreak;
        logic st_mis;
        logic ld_mis;
        logic mret;
    } exc_sel_t;

    // Index 0 is the highest priority; mret always loses to any exception.
    localparam int PRIO_ILL    = 0;
    localparam int PRIO_ECALL  = 1;
    localparam int PRIO_EBREAK = 2;
    localparam int PRIO_ST_MIS = 3;
    localparam int PRIO_LD_MIS = 4;
    localparam int PRIO_MRET   = 5;
    localparam int NUM_SRC     = 6;

    function automatic logic [NUM_SRC-1:0] prio_pick(input logic [NUM_SRC-1:0] raw);
        logic [NUM_SRC-1:0] win;
        logic               found;
        win   = {NUM_SRC{1'b0}};
        found = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (raw[i] && !found) begin
                win[i] = 1'b1;
                found  = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/trap_controller_if.sv
// Signal bundle between the trap controller and its neighbours
// (execute stage, CSR unit, fetch unit).
interface trap_controller_if #(
    parameter int XLEN = 32
);
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic            ex_illegal;
    logic            ex_ecall;
    logic            ex_ebreak;
    logic            ex_ld_misalign;
    logic            ex_st_misalign;
    logic            ex_mret;

    logic            exc_ill;
    logic            exc_ecall;
    logic            exc_ebreak;
    logic            exc_ld_mis;
    logic            exc_st_mis;
    logic [XLEN-1:0] exc_pc;

    logic            trap_req;
    logic [XLEN-1:0] trap_vector;

    logic            stall;
    logic            flush;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            redirect_ready;
    logic            trap_timeout;
    logic            busy;

    modport slave (
        input  ex_valid, ex_pc, ex_illegal, ex_ecall, ex_ebreak,
               ex_ld_misalign, ex_st_misalign, ex_mret,
               trap_req, trap_vector, redirect_ready,
        output exc_ill, exc_ecall, exc_ebreak, exc_ld_mis, exc_st_mis, exc_pc,
               stall, flush, redirect_valid, redirect_pc, trap_timeout, busy
    );

    modport master (
        output ex_valid, ex_pc, ex_illegal, ex_ecall, ex_ebreak,
               ex_ld_misalign, ex_st_misalign, ex_mret,
               trap_req, trap_vector, redirect_ready,
        input  exc_ill, exc_ecall, exc_ebreak, exc_ld_mis, exc_st_mis, exc_pc,
               stall, flush, redirect_valid, redirect_pc, trap_timeout, busy
    );

endinterface

// File: rtl/trap_controller_priority_enc.sv
// Combinational priority encoder: picks a single winning cause from the
// execute-stage event flags, qualified by the instruction valid.
module exc_priority_enc
    import trap_ctrl_pkg::*;
(
    input  logic     valid,
    input  logic     ill,
    input  logic     ecall,
    input  logic     ebreak,
    input  logic     ld_mis,
    input  logic     st_mis,
    input  logic     mret,
    output exc_sel_t sel,
    output logic     any_exc,
    output logic     is_mret
);

    logic [NUM_SRC-1:0] raw_s;
    logic [NUM_SRC-1:0] win_s;

    // Gather valid-qualified flags into priority order.
    always_comb begin
        raw_s              = {NUM_SRC{1'b0}};
        raw_s[PRIO_ILL]    = valid & ill;
        raw_s[PRIO_ECALL]  = valid & ecall;
        raw_s[PRIO_EBREAK] = valid & ebreak;
        raw_s[PRIO_ST_MIS] = valid & st_mis;
        raw_s[PRIO_LD_MIS] = valid & ld_mis;
        raw_s[PRIO_MRET]   = valid & mret;
    end

    assign win_s = prio_pick(raw_s);

    // Map the winning bit onto the cause struct and summary flags.
    always_comb begin
        sel.ill    = win_s[PRIO_ILL];
        sel.ecall  = win_s[PRIO_ECALL];
        sel.ebreak = win_s[PRIO_EBREAK];
        sel.st_mis = win_s[PRIO_ST_MIS];
        sel.ld_mis = win_s[PRIO_LD_MIS];
        sel.mret   = win_s[PRIO_MRET];
        any_exc    = |raw_s[PRIO_LD_MIS:PRIO_ILL];
        is_mret    = win_s[PRIO_MRET];
    end

endmodule

// File: rtl/trap_controller.sv
// Pipeline-side trap controller: raises one exception strobe to the CSR unit,
// waits for its trap request, then stalls/flushes and redirects fetch.
module trap_controller
    import trap_ctrl_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 8,
    parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
    input logic          clk,
    input logic          reset,
    trap_controller_if.slave bus
);

    exc_sel_t        sel_s;
    logic            any_exc_s;
    logic            is_mret_s;
    logic            expire_s;
    logic            timeout_s;

    state_t          state_r;
    logic [TO_W-1:0] cnt_r;
    logic [XLEN-1:0] exc_pc_r;
    logic [XLEN-1:0] redirect_pc_r;
    logic            exc_ill_r;
    logic            exc_ecall_r;
    logic            exc_ebreak_r;
    logic            exc_ld_mis_r;
    logic            exc_st_mis_r;
    logic            stall_r;
    logic            flush_r;
    logic            redirect_valid_r;
    logic            busy_r;

    exc_priority_enc u_enc (
        .valid   (bus.ex_valid),
        .ill     (bus.ex_illegal),
        .ecall   (bus.ex_ecall),
        .ebreak  (bus.ex_ebreak),
        .ld_mis  (bus.ex_ld_misalign),
        .st_mis  (bus.ex_st_misalign),
        .mret    (bus.ex_mret),
        .sel     (sel_s),
        .any_exc (any_exc_s),
        .is_mret (is_mret_s)
    );

    assign expire_s = (cnt_r == TO_W'(TIMEOUT - 1));

    // A late trap_req on the expiry cycle wins, so the pulse is qualified by it.
    always_comb begin
        timeout_s = 1'b0;
        if ((state_r == S_WAIT) && !bus.trap_req && expire_s) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Trap sequencing FSM with its counter, latched PCs and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r          <= S_IDLE;
            cnt_r            <= {TO_W{1'b0}};
            exc_pc_r         <= {XLEN{1'b0}};
            redirect_pc_r    <= {XLEN{1'b0}};
            exc_ill_r        <= 1'b0;
            exc_ecall_r      <= 1'b0;
            exc_ebreak_r     <= 1'b0;
            exc_ld_mis_r     <= 1'b0;
            exc_st_mis_r     <= 1'b0;
            stall_r          <= 1'b0;
            flush_r          <= 1'b0;
            redirect_valid_r <= 1'b0;
            busy_r           <= 1'b0;
        end else begin
            exc_ill_r    <= 1'b0;
            exc_ecall_r  <= 1'b0;
            exc_ebreak_r <= 1'b0;
            exc_ld_mis_r <= 1'b0;
            exc_st_mis_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (any_exc_s) begin
                        exc_ill_r    <= sel_s.ill;
                        exc_ecall_r  <= sel_s.ecall;
                        exc_ebreak_r <= sel_s.ebreak;
                        exc_ld_mis_r <= sel_s.ld_mis;
                        exc_st_mis_r <= sel_s.st_mis;
                        exc_pc_r     <= bus.ex_pc;
                        stall_r      <= 1'b1;
                        flush_r      <= 1'b1;
                        busy_r       <= 1'b1;
                        state_r      <= S_RAISE;
                    end else if (is_mret_s && sel_s.mret) begin
                        // MRET is handled entirely by the CSR unit; just wait for its redirect.
                        cnt_r   <= {TO_W{1'b0}};
                        stall_r <= 1'b1;
                        flush_r <= 1'b0;
                        busy_r  <= 1'b1;
                        state_r <= S_WAIT;
                    end else begin
                        stall_r          <= 1'b0;
                        flush_r          <= 1'b0;
                        redirect_valid_r <= 1'b0;
                        busy_r           <= 1'b0;
                        state_r          <= S_IDLE;
                    end
                end
                S_RAISE: begin
                    cnt_r   <= {TO_W{1'b0}};
                    stall_r <= 1'b1;
                    flush_r <= 1'b0;
                    state_r <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.trap_req) begin
                        redirect_pc_r    <= bus.trap_vector;
                        flush_r          <= 1'b1;
                        redirect_valid_r <= 1'b1;
                        state_r          <= S_REDIRECT;
                    end else if (expire_s) begin
                        stall_r <= 1'b0;
                        flush_r <= 1'b0;
                        busy_r  <= 1'b0;
                        state_r <= S_IDLE;
                    end else begin
                        cnt_r   <= (cnt_r == {TO_W{1'b1}}) ? cnt_r : cnt_r + TO_W'(1);
                        state_r <= S_WAIT;
                    end
                end
                S_REDIRECT: begin
                    if (bus.redirect_ready) begin
                        stall_r          <= 1'b0;
                        flush_r          <= 1'b0;
                        redirect_valid_r <= 1'b0;
                        busy_r           <= 1'b0;
                        state_r          <= S_IDLE;
                    end else begin
                        state_r <= S_REDIRECT;
                    end
                end
                default: begin
                    stall_r          <= 1'b0;
                    flush_r          <= 1'b0;
                    redirect_valid_r <= 1'b0;
                    busy_r           <= 1'b0;
                    state_r          <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.exc_ill        = exc_ill_r;
    assign bus.exc_ecall      = exc_ecall_r;
    assign bus.exc_ebreak     = exc_ebreak_r;
    assign bus.exc_ld_mis     = exc_ld_mis_r;
    assign bus.exc_st_mis     = exc_st_mis_r;
    assign bus.exc_pc         = exc_pc_r;
    assign bus.stall          = stall_r;
    assign bus.flush          = flush_r;
    assign bus.redirect_valid = redirect_valid_r;
    assign bus.redirect_pc    = redirect_pc_r;
    assign bus.trap_timeout   = timeout_s;
    assign bus.busy           = busy_r;

endmodule

// File: tb/tb_trap_controller.sv
// Directed, table-driven bench for trap_controller: each row is one clock
// cycle of inputs and the outputs expected during that same cycle.
module tb_trap_controller;

    localparam int XLEN    = 32;
    localparam int TIMEOUT = 8;

    localparam logic [5:0] F_NONE  = 6'b000000;
    localparam logic [5:0] F_ILL   = 6'b100000;
    localparam logic [5:0] F_ECALL = 6'b010000;
    localparam logic [5:0] F_EBRK  = 6'b001000;
    localparam logic [5:0] F_LD    = 6'b000100;
    localparam logic [5:0] F_ST    = 6'b000010;
    localparam logic [5:0] F_MRET  = 6'b000001;

    // expected strobes {ill, ecall, ebreak, ld, st}
    localparam logic [4:0] E_NONE  = 5'b00000;
    localparam logic [4:0] E_ILL   = 5'b10000;
    localparam logic [4:0] E_ECALL = 5'b01000;
    localparam logic [4:0] E_EBRK  = 5'b00100;
    localparam logic [4:0] E_LD    = 5'b00010;
    localparam logic [4:0] E_ST    = 5'b00001;

    // expected {stall, flush, redirect_valid}
    localparam logic [2:0] O_IDLE  = 3'b000;
    localparam logic [2:0] O_RAISE = 3'b110;
    localparam logic [2:0] O_WAIT  = 3'b100;
    localparam logic [2:0] O_REDIR = 3'b111;

    typedef struct {
        string       name;
        logic        rst;
        logic        v;
        logic [5:0]  fl;
        logic [31:0] pc;
        logic        treq;
        logic [31:0] vec;
        logic        rdy;
        logic [4:0]  x_exc;
        logic [31:0] x_pc;
        logic [2:0]  x_sfr;
        logic [31:0] x_rpc;
        logic        x_to;
        logic        x_busy;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   nvec = 0;
    int   nmis = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    trap_controller_if #(.XLEN(XLEN)) bus ();

    trap_controller #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic add(input string nm, input logic rst, input logic v, input logic [5:0] fl,
                       input logic [31:0] pc, input logic treq, input logic [31:0] vec, input logic rdy,
                       input logic [4:0] xe, input logic [31:0] xpc, input logic [2:0] sfr,
                       input logic [31:0] xrpc, input logic xto, input logic xbusy);
        vec_t r;
        r.name = nm; r.rst = rst; r.v = v; r.fl = fl; r.pc = pc; r.treq = treq; r.vec = vec; r.rdy = rdy;
        r.x_exc = xe; r.x_pc = xpc; r.x_sfr = sfr; r.x_rpc = xrpc; r.x_to = xto; r.x_busy = xbusy;
        tbl.push_back(r);
    endtask

    task automatic drive(input logic rst, input logic v, input logic [5:0] fl, input logic [31:0] pc,
                         input logic treq, input logic [31:0] vec, input logic rdy);
        reset = rst;
        bus.ex_valid = v;
        {bus.ex_illegal, bus.ex_ecall, bus.ex_ebreak, bus.ex_ld_misalign, bus.ex_st_misalign, bus.ex_mret} = fl;
        bus.ex_pc = pc;
        bus.trap_req = treq;
        bus.trap_vector = vec;
        bus.redirect_ready = rdy;
    endtask

    function automatic logic [73:0] observed();
        return {bus.exc_ill, bus.exc_ecall, bus.exc_ebreak, bus.exc_ld_mis, bus.exc_st_mis, bus.exc_pc,
                bus.stall, bus.flush, bus.redirect_valid, bus.redirect_pc, bus.trap_timeout, bus.busy};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [73:0] exp_v;
        logic [73:0] act_v;
        int n_strobe, n_to, n_rv, n_stall, to_idx, rv_k;
        logic treq_next;
        logic [31:0] rv_pc;

        drive(1'b1, 1'b0, F_NONE, 32'h0, 1'b0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);

        add("rst_state",      0,0,F_NONE,0,0,0,0,                 E_NONE,0,O_IDLE,0,0,0);
        add("ecall_det",      0,1,F_ECALL,32'h100,0,0,0,          E_NONE,0,O_IDLE,0,0,0);
        add("ecall_raise",    0,0,F_NONE,0,0,0,0,                 E_ECALL,32'h100,O_RAISE,0,0,1);
        add("ecall_wait0",    0,0,F_NONE,0,0,0,0,                 E_NONE,32'h100,O_WAIT,0,0,1);
        add("ecall_wait1",    0,0,F_NONE,0,1,32'h400,0,           E_NONE,32'h100,O_WAIT,0,0,1);
        add("ecall_redir",    0,0,F_NONE,0,0,0,1,                 E_NONE,32'h100,O_REDIR,32'h400,0,1);
        add("ecall_done",     0,0,F_NONE,0,0,0,0,                 E_NONE,32'h100,O_IDLE,32'h400,0,0);
        add("multi_det",      0,1,F_ILL|F_ECALL|F_LD,32'h200,0,0,0, E_NONE,32'h100,O_IDLE,32'h400,0,0);
        add("multi_raise",    0,1,F_ILL|F_ECALL|F_LD,32'h200,0,0,0, E_ILL,32'h200,O_RAISE,32'h400,0,1);
        add("multi_wait",     0,1,F_ILL|F_ECALL|F_LD,32'h200,1,32'h300,0, E_NONE,32'h200,O_WAIT,32'h400,0,1);
        add("multi_redir",    0,0,F_NONE,0,0,0,1,                 E_NONE,32'h200,O_REDIR,32'h300,0,1);
        add("multi_done",     0,0,F_NONE,0,0,0,0,                 E_NONE,32'h200,O_IDLE,32'h300,0,0);
        add("mret_det",       0,1,F_MRET,32'h50,0,0,0,            E_NONE,32'h200,O_IDLE,32'h300,0,0);
        add("mret_wait",      0,0,F_NONE,0,1,32'h104,0,           E_NONE,32'h200,O_WAIT,32'h300,0,1);
        add("mret_redir",     0,0,F_NONE,0,0,0,1,                 E_NONE,32'h200,O_REDIR,32'h104,0,1);
        add("mret_done",      0,0,F_NONE,0,0,0,0,                 E_NONE,32'h200,O_IDLE,32'h104,0,0);
        add("prio_ebrk_det",  0,1,F_EBRK|F_ST|F_MRET,32'h60,0,0,0, E_NONE,32'h200,O_IDLE,32'h104,0,0);
        add("prio_ebrk_raise",1,0,F_NONE,0,0,0,0,                 E_EBRK,32'h60,O_RAISE,32'h104,0,1);
        add("prio_st_det",    0,1,F_ST|F_LD,32'h70,0,0,0,         E_NONE,0,O_IDLE,0,0,0);
        add("prio_st_raise",  1,0,F_NONE,0,0,0,0,                 E_ST,32'h70,O_RAISE,0,0,1);
        add("prio_ld_det",    0,1,F_LD,32'h74,0,0,0,              E_NONE,0,O_IDLE,0,0,0);
        add("prio_ld_raise",  1,0,F_NONE,0,0,0,0,                 E_LD,32'h74,O_RAISE,0,0,1);
        add("novalid_flags",  0,0,F_ILL,32'h78,0,0,0,             E_NONE,0,O_IDLE,0,0,0);
        add("idle_treq",      0,0,F_NONE,0,1,32'hDEAD,0,          E_NONE,0,O_IDLE,0,0,0);
        add("idle_after",     0,0,F_NONE,0,0,0,0,                 E_NONE,0,O_IDLE,0,0,0);
        add("to_det",         0,1,F_EBRK,32'h300,0,0,0,           E_NONE,0,O_IDLE,0,0,0);
        add("to_raise",       0,0,F_NONE,0,0,0,0,                 E_EBRK,32'h300,O_RAISE,0,0,1);
        for (int i = 0; i < TIMEOUT; i++)
            add($sformatf("to_wait%0d", i), 0,0,F_NONE,0,0,0,0, E_NONE,32'h300,O_WAIT,0,(i == TIMEOUT-1),1);
        add("to_done",        0,0,F_NONE,0,0,0,0,                 E_NONE,32'h300,O_IDLE,0,0,0);
        add("tie_det",        0,1,F_ECALL,32'h310,0,0,0,          E_NONE,32'h300,O_IDLE,0,0,0);
        add("tie_raise",      0,0,F_NONE,0,0,0,0,                 E_ECALL,32'h310,O_RAISE,0,0,1);
        for (int i = 0; i < TIMEOUT-1; i++)
            add($sformatf("tie_wait%0d", i), 0,0,F_NONE,0,0,0,0, E_NONE,32'h310,O_WAIT,0,0,1);
        add("tie_req",        0,0,F_NONE,0,1,32'h800,0,           E_NONE,32'h310,O_WAIT,0,0,1);
        for (int i = 0; i < 5; i++)
            add($sformatf("hold%0d", i), 0,0,F_NONE,0,0,(i >= 2) ? 32'h900 : 32'h800,0, E_NONE,32'h310,O_REDIR,32'h800,0,1);
        add("hold_accept",    0,0,F_NONE,0,0,32'h900,1,           E_NONE,32'h310,O_REDIR,32'h800,0,1);
        add("hold_done",      0,0,F_NONE,0,0,0,0,                 E_NONE,32'h310,O_IDLE,32'h800,0,0);
        add("rw_det",         0,1,F_ILL,32'h400,0,0,0,            E_NONE,32'h310,O_IDLE,32'h800,0,0);
        add("rw_raise",       0,0,F_NONE,0,0,0,0,                 E_ILL,32'h400,O_RAISE,32'h800,0,1);
        add("rw_wait_rst",    1,0,F_NONE,0,0,0,0,                 E_NONE,32'h400,O_WAIT,32'h800,0,1);
        add("rw_after",       0,0,F_NONE,0,0,0,0,                 E_NONE,0,O_IDLE,0,0,0);
        add("rr_mret",        0,1,F_MRET,32'h410,0,0,0,           E_NONE,0,O_IDLE,0,0,0);
        add("rr_wait",        0,0,F_NONE,0,1,32'hA00,0,           E_NONE,0,O_WAIT,0,0,1);
        add("rr_redir_rst",   1,0,F_NONE,0,0,0,0,                 E_NONE,0,O_REDIR,32'hA00,0,1);
        add("rr_after",       0,0,F_NONE,0,0,0,0,                 E_NONE,0,O_IDLE,0,0,0);
        add("post_det",       0,1,F_ECALL,32'h500,0,0,0,          E_NONE,0,O_IDLE,0,0,0);
        add("post_raise",     0,0,F_NONE,0,0,0,0,                 E_ECALL,32'h500,O_RAISE,0,0,1);
        add("post_wait",      0,0,F_NONE,0,1,32'h600,0,           E_NONE,32'h500,O_WAIT,0,0,1);
        add("post_redir",     0,0,F_NONE,0,0,0,1,                 E_NONE,32'h500,O_REDIR,32'h600,0,1);
        add("post_done",      0,0,F_NONE,0,0,0,0,                 E_NONE,32'h500,O_IDLE,32'h600,0,0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].v, tbl[i].fl, tbl[i].pc, tbl[i].treq, tbl[i].vec, tbl[i].rdy);
            #3;
            exp_v = {tbl[i].x_exc, tbl[i].x_pc, tbl[i].x_sfr, tbl[i].x_rpc, tbl[i].x_to, tbl[i].x_busy};
            act_v = observed();
            nvec++;
            if (act_v !== exp_v) begin
                nmis++;
                $display("FAIL %s (row %0d): got %h expected %h", tbl[i].name, i, act_v, exp_v);
            end
        end

        // ebreak with no CSR response: count strobes, stall cycles and timeout position.
        @(negedge clk);
        drive(1'b0, 1'b1, F_EBRK, 32'h700, 1'b0, 32'h0, 1'b0);
        n_strobe = 0; n_to = 0; n_rv = 0; n_stall = 0; to_idx = -1;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            drive(1'b0, 1'b0, F_NONE, 32'h0, 1'b0, 32'h0, 1'b0);
            #3;
            if (bus.exc_ill | bus.exc_ecall | bus.exc_ebreak | bus.exc_ld_mis | bus.exc_st_mis) n_strobe++;
            if (bus.trap_timeout) begin
                n_to++;
                to_idx = k;
            end
            if (bus.redirect_valid) n_rv++;
            if (bus.stall) n_stall++;
        end
        chk("seqA_strobes", n_strobe, 1);
        chk("seqA_timeouts", n_to, 1);
        chk("seqA_timeout_cycle", to_idx, 8);
        chk("seqA_redirects", n_rv, 0);
        chk("seqA_stall_cycles", n_stall, 9);
        chk("seqA_busy_end", {31'b0, bus.busy}, 0);

        // illegal with a registered CSR model: redirect_valid two cycles after the strobe.
        @(negedge clk);
        drive(1'b0, 1'b1, F_ILL, 32'h800, 1'b0, 32'h0, 1'b1);
        treq_next = 1'b0; rv_k = -1; rv_pc = 32'h0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            drive(1'b0, 1'b0, F_NONE, 32'h0, treq_next, 32'hC00, 1'b1);
            #3;
            treq_next = bus.exc_ill;
            if (bus.redirect_valid && rv_k < 0) begin
                rv_k  = k;
                rv_pc = bus.redirect_pc;
            end
        end
        chk("seqB_redirect_cycle", rv_k, 2);
        chk("seqB_redirect_pc", rv_pc, 32'hC00);
        chk("seqB_exc_pc", bus.exc_pc, 32'h800);
        chk("seqB_busy_end", {31'b0, bus.busy}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/trap_controller.md
Name: trap_controller

Overview:
- Pipeline-side counterpart of the CSR trap logic.
- Collects exception and MRET events from the execute stage, prioritizes them, and sends exactly one single-cycle exception strobe plus the faulting PC to the CSR unit.
- Waits for the CSR unit's trap request and trap vector, then stalls and flushes the pipeline and redirects fetch to the vector through a valid/ready handshake.
- Sits between the execute stage, the CSR unit and the fetch unit.

Parameters:
- XLEN, 32, data/PC width.
- TIMEOUT, 8, maximum cycles spent in WAIT for trap_req before abandoning the event.
- TO_W, $clog2(TIMEOUT+1), timeout counter width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ex_valid  in  1  execute-stage instruction valid
- ex_pc  in  XLEN  PC of the execute-stage instruction
- ex_illegal, ex_ecall, ex_ebreak, ex_ld_misalign, ex_st_misalign, ex_mret  in  1 each  event flags, qualified by ex_valid
- exc_ill, exc_ecall, exc_ebreak, exc_ld_mis, exc_st_mis  out  1 each  one-hot strobes to the CSR unit
- exc_pc  out  XLEN  faulting PC to the CSR unit
- trap_req  in  1  CSR trap/return request pulse
- trap_vector  in  XLEN  CSR redirect target, valid with trap_req
- stall  out  1  freeze IF/ID/EX
- flush  out  1  squash younger instructions
- redirect_valid  out  1  fetch redirect request
- redirect_pc  out  XLEN  fetch redirect target
- redirect_ready  in  1  fetch accepted the redirect
- trap_timeout  out  1  one-cycle pulse: no trap_req arrived before the timeout
- busy  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE; all exc_* strobes, stall, flush, redirect_valid, trap_timeout and busy are 0; exc_pc=0; redirect_pc=0; counter=0. Reset asserted in any state aborts the operation within one cycle, with no strobe or redirect emitted.
- Priority, single winner: illegal > ecall > ebreak > st_misalign > ld_misalign > mret. Any exception flag suppresses mret.
- IDLE:
  - ex_valid with any exception flag -> latch winner and ex_pc; go to RAISE.
  - ex_valid with ex_mret only -> clear counter; go to WAIT. No strobe; the CSR unit handles MRET itself.
  - Flags with ex_valid=0 are ignored.
  - trap_req seen in IDLE is ignored.
- RAISE (1 cycle):
  - Exactly one exc_* strobe is high; exc_pc = latched PC; stall=1; flush=1.
  - Clear counter; go to WAIT.
- WAIT:
  - stall=1; flush=0.
  - trap_req=1 -> capture trap_vector into redirect_pc; go to REDIRECT.
  - Otherwise increment the counter. When counter==TIMEOUT-1 and trap_req=0, pulse trap_timeout for that cycle and go to IDLE. This covers the CSR already being trapped, which ignores nested exceptions.
  - trap_req on the same cycle as expiry: trap_req wins and no timeout pulse is issued.
- REDIRECT:
  - stall=1; flush=1; redirect_valid=1; redirect_pc stays stable until handshake.
  - redirect_ready=1 -> go to IDLE. redirect_valid and flush drop the next cycle.
- Latency:
  - Exception: detection edge N; strobe during cycle N+1; the CSR registers trap_req, so it is high in cycle N+2; redirect_valid from cycle N+3.
  - MRET: WAIT from the cycle after detection.
- New ex_* events are not sampled outside IDLE. The pipeline is stalled, so the instruction is re-presented, and after the flush it is gone.
- trap_vector is sampled only on trap_req; later changes have no effect.
- The counter saturates and never wraps.

Decomposition:
- Package trap_ctrl_pkg:
  - state enum {IDLE, RAISE, WAIT, REDIRECT};
  - exc_sel_t one-hot struct of five causes plus mret;
  - priority order constants.
- Sub-module exc_priority_enc: combinational; flags in -> exc_sel_t one-hot plus any_exc/is_mret out.
- The FSM, counter and registers live in trap_controller.

Test Plan:
- ecall at ex_pc=0x0000_0100; trap_req with trap_vector=0x0000_0400 two cycles later; redirect_ready=1 on first request -> exc_ecall high exactly 1 cycle with exc_pc=0x100; redirect_pc=0x400; stall high 4 cycles; busy low afterwards.
- illegal+ecall+ld_misalign together at pc=0x200 -> only exc_ill strobes; the other strobes stay 0 throughout.
- mret alone, trap_req with vector=0x104 one cycle later -> no exc_* strobe; redirect_pc=0x104; flush high only in REDIRECT.
- ebreak with trap_req never asserted -> trap_timeout pulses exactly once at WAIT cycle TIMEOUT (8); return to IDLE; redirect_valid never high.
- redirect_ready held low 5 cycles, vector=0x800 -> redirect_valid and redirect_pc=0x800 held stable all 5 cycles; a trap_vector change to 0x900 mid-hold has no effect.
- reset asserted during WAIT and during REDIRECT -> next cycle all outputs 0 and state IDLE; an exception presented after reset is processed normally.
